// File: rtl/vmu_spm_bank_if.sv
// VMU-to-SPM bank access channel: one read port and one write port per cycle,
// plus the bank's read-return, address-error and write-occupancy outputs.
// MEMW_DELAY must match the bank instance so the occupancy count is sized alike.
interface vmu_spm_bank_if #(
  parameter int SCALAR_WIDTH = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int MEMW_DELAY   = 1
);

  logic                                i_spm_rden;
  logic [SCALAR_WIDTH-1:0]             i_spm_rdaddr;
  logic                                i_spm_wren;
  logic [SCALAR_WIDTH-1:0]             i_spm_wraddr;
  logic [DATA_WIDTH-1:0]               i_spm_wdata;
  logic                                o_spm_rdata_vld;
  logic [DATA_WIDTH-1:0]               o_spm_rdata;
  logic                                o_spm_addr_err;
  logic [$clog2(MEMW_DELAY+1)-1:0]     o_spm_wr_inflight;

  modport master (
    output i_spm_rden, i_spm_rdaddr, i_spm_wren, i_spm_wraddr, i_spm_wdata,
    input  o_spm_rdata_vld, o_spm_rdata, o_spm_addr_err, o_spm_wr_inflight
  );

  modport slave (
    input  i_spm_rden, i_spm_rdaddr, i_spm_wren, i_spm_wraddr, i_spm_wdata,
    output o_spm_rdata_vld, o_spm_rdata, o_spm_addr_err, o_spm_wr_inflight
  );

endinterface

// File: rtl/vmu_spm_bank.sv
// Single scratchpad bank behind one VMU LSU channel. Writes commit after a
// fixed MEMW_DELAY pipe (the cycle a write is presented counts as its first
// stage), reads return exactly MEMR_DELAY cycles after issue. Out-of-range
// accesses raise a sticky error; bad writes are dropped, bad reads return 0.
// Optional macro VMU_SPM_BYPASS_EN: forward the youngest in-flight or
// committing write to a read of the same address.
// SCALAR_WIDTH must be larger than $clog2(DEPTH).
module vmu_spm_bank #(
  parameter int SCALAR_WIDTH = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH        = 1024,
  parameter int MEMR_DELAY   = 2,
  parameter int MEMW_DELAY   = 1
) (
  input logic             clk,
  input logic             rst,
  vmu_spm_bank_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  // Registered write stages behind the presentation cycle; one dummy stage
  // that never becomes valid keeps the arrays legal when MEMW_DELAY is 1.
  localparam int PW = (MEMW_DELAY > 1) ? MEMW_DELAY - 1 : 1;
  localparam int IW = $clog2(MEMW_DELAY + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]         rd_idx;
  logic [AW-1:0]         wr_idx;
  logic                  rd_oob;
  logic                  wr_oob;
  logic                  rd_acc;
  logic                  wr_acc;

  logic [PW-1:0]         pvld;
  logic [AW-1:0]         paddr [PW];
  logic [DATA_WIDTH-1:0] pdata [PW];

  logic                  cm_vld;
  logic [AW-1:0]         cm_addr;
  logic [DATA_WIDTH-1:0] cm_data;

  logic [MEMR_DELAY-1:0] rvld;
  logic [DATA_WIDTH-1:0] rdat [MEMR_DELAY];

  logic                  addr_err;
  logic [IW-1:0]         inflight;

  assign rd_idx = bus.i_spm_rdaddr[AW-1:0];
  assign wr_idx = bus.i_spm_wraddr[AW-1:0];
  assign rd_oob = |bus.i_spm_rdaddr[SCALAR_WIDTH-1:AW];
  assign wr_oob = |bus.i_spm_wraddr[SCALAR_WIDTH-1:AW];
  assign rd_acc = bus.i_spm_rden & ~rst;
  assign wr_acc = bus.i_spm_wren & ~wr_oob & ~rst;

  // Write-pipe valids: cleared on reset so pending writes are never committed.
  always_ff @(posedge clk) begin
    if (rst) begin
      pvld <= '0;
    end else begin
      pvld[0] <= (MEMW_DELAY > 1) && wr_acc;
      for (int i = 1; i < PW; i++) begin
        pvld[i] <= pvld[i-1];
      end
    end
  end

  // Write-pipe payload shifts every cycle; only the valid bits matter.
  always_ff @(posedge clk) begin
    paddr[0] <= wr_idx;
    pdata[0] <= bus.i_spm_wdata;
    for (int i = 1; i < PW; i++) begin
      paddr[i] <= paddr[i-1];
      pdata[i] <= pdata[i-1];
    end
  end

  assign cm_vld  = (MEMW_DELAY == 1) ? wr_acc : (pvld[PW-1] & ~rst);
  assign cm_addr = (MEMW_DELAY == 1) ? wr_idx : paddr[PW-1];
  assign cm_data = (MEMW_DELAY == 1) ? bus.i_spm_wdata : pdata[PW-1];

  // Array commit from the oldest write stage.
  always_ff @(posedge clk) begin
    if (cm_vld) begin
      mem[cm_addr] <= cm_data;
    end
  end

`ifdef VMU_SPM_BYPASS_EN
  logic                  byp_hit;
  logic [DATA_WIDTH-1:0] byp_data;

  // Forwarding search, oldest stage first so younger matches overwrite.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    for (int i = PW - 1; i >= 0; i--) begin
      if (pvld[i] && (paddr[i] == rd_idx)) begin
        byp_hit  = 1'b1;
        byp_data = pdata[i];
      end
    end
    if (wr_acc && (wr_idx == rd_idx)) begin
      byp_hit  = 1'b1;
      byp_data = bus.i_spm_wdata;
    end
  end
`endif

  // Read pipe: capture at issue edge, shift, and hold data while not valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvld <= '0;
      for (int i = 0; i < MEMR_DELAY; i++) begin
        rdat[i] <= '0;
      end
    end else begin
      rvld[0] <= rd_acc;
      for (int i = 1; i < MEMR_DELAY; i++) begin
        rvld[i] <= rvld[i-1];
      end
      if (rd_acc) begin
        if (rd_oob) begin
          rdat[0] <= '0;
`ifdef VMU_SPM_BYPASS_EN
        end else if (byp_hit) begin
          rdat[0] <= byp_data;
`endif
        end else begin
          rdat[0] <= mem[rd_idx];
        end
      end
      for (int i = 1; i < MEMR_DELAY; i++) begin
        if (rvld[i-1]) begin
          rdat[i] <= rdat[i-1];
        end
      end
    end
  end

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else if ((bus.i_spm_rden & rd_oob) | (bus.i_spm_wren & wr_oob)) begin
      addr_err <= 1'b1;
    end
  end

  // Occupancy: the write presented this cycle plus every valid pipe stage.
  always_comb begin
    inflight = IW'(wr_acc);
    for (int i = 0; i < PW; i++) begin
      inflight = inflight + IW'(pvld[i]);
    end
  end

  assign bus.o_spm_rdata_vld   = rvld[MEMR_DELAY-1];
  assign bus.o_spm_rdata       = rdat[MEMR_DELAY-1];
  assign bus.o_spm_addr_err    = addr_err;
  assign bus.o_spm_wr_inflight = inflight;

endmodule

// File: tb/tb_vmu_spm_bank.sv
// Directed bench for vmu_spm_bank: a default bank (MEMW_DELAY=1) and a
// MEMW_DELAY=3 bank side by side, each cycle driven just after the rising edge.
module tb_vmu_spm_bank;

  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;

`ifdef VMU_SPM_BYPASS_EN
  localparam logic [63:0] SAME_CYCLE_EXP = 64'h22;
`else
  localparam logic [63:0] SAME_CYCLE_EXP = 64'h11;
`endif

  vmu_spm_bank_if #(.SCALAR_WIDTH(32), .DATA_WIDTH(64), .MEMW_DELAY(1)) bus_a ();
  vmu_spm_bank_if #(.SCALAR_WIDTH(32), .DATA_WIDTH(64), .MEMW_DELAY(3)) bus_b ();

  vmu_spm_bank #(
    .SCALAR_WIDTH(32), .DATA_WIDTH(64), .DEPTH(1024), .MEMR_DELAY(2), .MEMW_DELAY(1)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  vmu_spm_bank #(
    .SCALAR_WIDTH(32), .DATA_WIDTH(64), .DEPTH(1024), .MEMR_DELAY(2), .MEMW_DELAY(3)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Guard against a run that never reaches its summary.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
    end
  endtask

  // Start a new cycle on bank sel (0 = A, 1 = B); the other bank idles.
  task automatic applyStimulus(input int sel, input logic rden, input logic [31:0] raddr,
                               input logic wren, input logic [31:0] waddr,
                               input logic [63:0] wdata);
    @(posedge clk);
    #1;
    bus_a.i_spm_rden   = (sel == 0) ? rden : 1'b0;
    bus_a.i_spm_wren   = (sel == 0) ? wren : 1'b0;
    bus_b.i_spm_rden   = (sel == 1) ? rden : 1'b0;
    bus_b.i_spm_wren   = (sel == 1) ? wren : 1'b0;
    bus_a.i_spm_rdaddr = raddr;
    bus_a.i_spm_wraddr = waddr;
    bus_a.i_spm_wdata  = wdata;
    bus_b.i_spm_rdaddr = raddr;
    bus_b.i_spm_wraddr = waddr;
    bus_b.i_spm_wdata  = wdata;
    #1;
  endtask

  task automatic idleCycle(input int sel);
    applyStimulus(sel, 1'b0, 32'd0, 1'b0, 32'd0, 64'd0);
  endtask

  // Main directed sequence.
  initial begin
    rst = 1'b1;
    bus_a.i_spm_rden = 1'b0; bus_a.i_spm_wren = 1'b0;
    bus_a.i_spm_rdaddr = '0; bus_a.i_spm_wraddr = '0; bus_a.i_spm_wdata = '0;
    bus_b.i_spm_rden = 1'b0; bus_b.i_spm_wren = 1'b0;
    bus_b.i_spm_rdaddr = '0; bus_b.i_spm_wraddr = '0; bus_b.i_spm_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_a_vld",      bus_a.o_spm_rdata_vld,   64'd0);
    checkOutput("rst_a_rdata",    bus_a.o_spm_rdata,       64'd0);
    checkOutput("rst_a_err",      bus_a.o_spm_addr_err,    64'd0);
    checkOutput("rst_a_inflight", bus_a.o_spm_wr_inflight, 64'd0);
    checkOutput("rst_b_vld",      bus_b.o_spm_rdata_vld,   64'd0);
    checkOutput("rst_b_rdata",    bus_b.o_spm_rdata,       64'd0);
    checkOutput("rst_b_err",      bus_b.o_spm_addr_err,    64'd0);
    checkOutput("rst_b_inflight", bus_b.o_spm_wr_inflight, 64'd0);
    rst = 1'b0;

    // Basic write then read with fixed latency.
    applyStimulus(0, 1'b0, 32'd0, 1'b1, 32'd5, 64'h1234);
    checkOutput("t1_inflight_wr", bus_a.o_spm_wr_inflight, 64'd1);
    idleCycle(0);
    checkOutput("t1_inflight_idle", bus_a.o_spm_wr_inflight, 64'd0);
    applyStimulus(0, 1'b1, 32'd5, 1'b0, 32'd0, 64'd0);
    checkOutput("t1_vld_c2", bus_a.o_spm_rdata_vld, 64'd0);
    idleCycle(0);
    checkOutput("t1_vld_c3", bus_a.o_spm_rdata_vld, 64'd0);
    idleCycle(0);
    checkOutput("t1_vld_c4", bus_a.o_spm_rdata_vld, 64'd1);
    checkOutput("t1_rdata_c4", bus_a.o_spm_rdata, 64'h1234);
    idleCycle(0);
    checkOutput("t1_vld_c5", bus_a.o_spm_rdata_vld, 64'd0);
    checkOutput("t1_rdata_hold", bus_a.o_spm_rdata, 64'h1234);

    // Same-cycle read and write to one address.
    applyStimulus(0, 1'b0, 32'd0, 1'b1, 32'd7, 64'h11);
    applyStimulus(0, 1'b1, 32'd7, 1'b1, 32'd7, 64'h22);
    idleCycle(0);
    idleCycle(0);
    checkOutput("t2_vld_same", bus_a.o_spm_rdata_vld, 64'd1);
    checkOutput("t2_rdata_same", bus_a.o_spm_rdata, SAME_CYCLE_EXP);
    applyStimulus(0, 1'b1, 32'd7, 1'b0, 32'd0, 64'd0);
    idleCycle(0);
    idleCycle(0);
    checkOutput("t2_vld_later", bus_a.o_spm_rdata_vld, 64'd1);
    checkOutput("t2_rdata_later", bus_a.o_spm_rdata, 64'h22);

    // Out-of-range write and read.
    applyStimulus(0, 1'b0, 32'd0, 1'b1, 32'd0, 64'hAA);
    applyStimulus(0, 1'b0, 32'd0, 1'b1, 32'd1024, 64'hFF);
    checkOutput("t3_err_before", bus_a.o_spm_addr_err, 64'd0);
    checkOutput("t3_inflight_oob", bus_a.o_spm_wr_inflight, 64'd0);
    applyStimulus(0, 1'b1, 32'd0, 1'b0, 32'd0, 64'd0);
    checkOutput("t3_err_set", bus_a.o_spm_addr_err, 64'd1);
    idleCycle(0);
    idleCycle(0);
    checkOutput("t3_vld_addr0", bus_a.o_spm_rdata_vld, 64'd1);
    checkOutput("t3_rdata_addr0", bus_a.o_spm_rdata, 64'hAA);
    applyStimulus(0, 1'b1, 32'd2048, 1'b0, 32'd0, 64'd0);
    idleCycle(0);
    idleCycle(0);
    checkOutput("t3_vld_oob", bus_a.o_spm_rdata_vld, 64'd1);
    checkOutput("t3_rdata_oob", bus_a.o_spm_rdata, 64'd0);
    idleCycle(0);
    checkOutput("t3_vld_after", bus_a.o_spm_rdata_vld, 64'd0);
    checkOutput("t3_err_sticky", bus_a.o_spm_addr_err, 64'd1);

    // Back-to-back reads after preloading value = address.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1'b0, 32'd0, 1'b1, 32'(i), 64'(i));
    end
    for (int k = 0; k < 11; k++) begin
      applyStimulus(0, (k < 8), 32'(k), 1'b0, 32'd0, 64'd0);
      if (k >= 2 && k < 10) begin
        checkOutput($sformatf("t4_vld_%0d", k), bus_a.o_spm_rdata_vld, 64'd1);
        checkOutput($sformatf("t4_rdata_%0d", k), bus_a.o_spm_rdata, 64'(k - 2));
      end else begin
        checkOutput($sformatf("t4_vld_%0d", k), bus_a.o_spm_rdata_vld, 64'd0);
      end
    end

    // Deep write pipe occupancy on bank B.
    applyStimulus(1, 1'b0, 32'd0, 1'b1, 32'd10, 64'h100);
    applyStimulus(1, 1'b0, 32'd0, 1'b1, 32'd11, 64'h101);
    repeat (3) idleCycle(1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1'b0, 32'd0, 1'b1, 32'(20 + i), 64'(32'h200 + i));
      checkOutput($sformatf("t5_inflight_up%0d", i), bus_b.o_spm_wr_inflight, 64'(i + 1));
    end
    for (int i = 0; i < 3; i++) begin
      idleCycle(1);
      checkOutput($sformatf("t5_inflight_dn%0d", i), bus_b.o_spm_wr_inflight, 64'(2 - i));
    end

    // Reset while two writes and one read are in flight.
    applyStimulus(1, 1'b0, 32'd0, 1'b1, 32'd10, 64'hBAD);
    applyStimulus(1, 1'b1, 32'd10, 1'b1, 32'd11, 64'hBEE);
    idleCycle(1);
    checkOutput("t5_inflight_prerst", bus_b.o_spm_wr_inflight, 64'd2);
    rst = 1'b1;
    idleCycle(1);
    checkOutput("t5_inflight_rst", bus_b.o_spm_wr_inflight, 64'd0);
    checkOutput("t5_vld_rst", bus_b.o_spm_rdata_vld, 64'd0);
    rst = 1'b0;
    idleCycle(1);
    checkOutput("t5_vld_post", bus_b.o_spm_rdata_vld, 64'd0);
    applyStimulus(1, 1'b1, 32'd10, 1'b0, 32'd0, 64'd0);
    applyStimulus(1, 1'b1, 32'd11, 1'b0, 32'd0, 64'd0);
    applyStimulus(1, 1'b1, 32'd22, 1'b0, 32'd0, 64'd0);
    checkOutput("t5_rdata_addr10", bus_b.o_spm_rdata, 64'h100);
    idleCycle(1);
    checkOutput("t5_rdata_addr11", bus_b.o_spm_rdata, 64'h101);
    idleCycle(1);
    checkOutput("t5_vld_addr22", bus_b.o_spm_rdata_vld, 64'd1);
    checkOutput("t5_rdata_addr22", bus_b.o_spm_rdata, 64'h202);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
